// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the KxK line-buffer convolution datapath: streams an NxN frame in,
// flushes the pipe, and tags valid-window results. Optional stall counter: CONV_SEQ_STALL_CNT_EN.
module conv_frame_sequencer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int K_SIZE     = 3,
  parameter int PIPE_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pix_valid,
  input  logic [DATA_WIDTH-1:0]   pix_data,
  output logic                    pix_ready,
  output logic                    conv_en,
  output logic [DATA_WIDTH-1:0]   conv_data,
  input  logic [DATA_WIDTH-1:0]   conv_res,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(N)-1:0]    out_row,
  output logic [$clog2(N)-1:0]    out_col,
  output logic                    busy,
  output logic                    done
`ifdef CONV_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int RW = $clog2(N);
  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [RW-1:0] KM1  = RW'(K_SIZE - 1);
  localparam logic [RW-1:0] LAST = RW'(N - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   r_col;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_busy;
  logic            r_done;

  logic            r_tag_ok  [PIPE_LAT];
  logic [RW-1:0]   r_tag_row [PIPE_LAT];
  logic [RW-1:0]   r_tag_col [PIPE_LAT];

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [RW-1:0]         r_out_row;
  logic [RW-1:0]         r_out_col;

  logic            w_accept;
  logic            w_flush;
  logic            w_last;
  logic            w_win_ok;
  logic [RW-1:0]   w_trow;
  logic [RW-1:0]   w_tcol;

  assign pix_ready = (r_state == S_RUN);
  assign w_accept  = pix_valid & pix_ready;
  assign w_flush   = (r_state == S_FLUSH);
  assign conv_en   = w_accept | w_flush;
  assign conv_data = w_accept ? pix_data : '0;
  assign w_last    = w_accept && (r_row == LAST) && (r_col == LAST);

  // Flush beats push a zero tag so trailing junk can never be flagged.
  assign w_win_ok = w_accept && (r_row >= KM1) && (r_col >= KM1);
  assign w_trow   = w_accept ? (r_row - KM1) : '0;
  assign w_tcol   = w_accept ? (r_col - KM1) : '0;

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state     <= S_FLUSH;
            r_row       <= '0;
            r_col       <= '0;
            r_flush_cnt <= '0;
          end else if (w_accept) begin
            if (r_col == LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == FLUSH_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag pipe stage: tags move only on datapath beats, matching the datapath's latency in beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_tag_ok[i]  <= 1'b0;
        r_tag_row[i] <= '0;
        r_tag_col[i] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else if (conv_en) begin
      r_tag_ok[0]  <= w_win_ok;
      r_tag_row[0] <= w_trow;
      r_tag_col[0] <= w_tcol;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_tag_ok[i]  <= r_tag_ok[i-1];
        r_tag_row[i] <= r_tag_row[i-1];
        r_tag_col[i] <= r_tag_col[i-1];
      end
      r_out_valid <= r_tag_ok[PIPE_LAT-1];
      r_out_data  <= conv_res;
      r_out_row   <= r_tag_row[PIPE_LAT-1];
      r_out_col   <= r_tag_col[PIPE_LAT-1];
    end else begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && !pix_valid) begin
      r_stall_cnt <= sat_inc32(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer with a behavioural 3x3 all-ones (Q5) datapath.
module tb_conv_frame_sequencer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int K  = 3;
  localparam int PL = 1;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          conv_en;
  logic [DW-1:0] conv_data;
  logic [DW-1:0] conv_res;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic          busy;
  logic          done;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  conv_frame_sequencer #(
    .N(N), .DATA_WIDTH(DW), .K_SIZE(K), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .conv_en(conv_en), .conv_data(conv_data), .conv_res(conv_res),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
`ifdef CONV_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Line-buffer datapath stand-in: window sum over taps 0,1,2,N..N+2,2N..2N+2 behind newest.
  logic [10:0][DW-1:0] sr;

  function automatic logic [DW-1:0] win_sum(input logic [10:0][DW-1:0] w);
    return w[0] + w[1] + w[2] + w[4] + w[5] + w[6] + w[8] + w[9] + w[10];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      conv_res <= '0;
    end else if (conv_en) begin
      sr       <= {sr[9:0], conv_data};
      conv_res <= win_sum({sr[9:0], conv_data});
    end
  end

  int            n_res  = 0;
  int            n_done = 0;
  int            n_en   = 0;
  logic [DW-1:0] rec_dat [0:63];
  logic [RW-1:0] rec_row [0:63];
  logic [RW-1:0] rec_col [0:63];

  always @(negedge clk) begin
    if (out_valid) begin
      if (n_res < 64) begin
        rec_dat[n_res] = out_data;
        rec_row[n_res] = out_row;
        rec_col[n_res] = out_col;
      end
      n_res = n_res + 1;
    end
    if (done)    n_done = n_done + 1;
    if (conv_en) n_en   = n_en + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window sums of pixels 0..15 for the four valid windows, before base offset and Q5 scale.
  function automatic int exp_sum(input int j, input int base);
    int s;
    case (j)
      0:       s = 45;
      1:       s = 54;
      2:       s = 81;
      default: s = 90;
    endcase
    return (s + 9 * base) * 32;
  endfunction

  // Entered at posedge+1 with the sequencer idle; leaves at posedge+1 after DONE.
  task automatic run_frame(input int base, input bit gapped, input bit noise);
    int r0 = n_res;
    int e0 = n_en;
    int d0 = n_done;
    bit got = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_in_run", busy, 1);
    for (int i = 0; i < N * N; i++) begin
      pix_valid = 1'b1;
      pix_data  = DW'((base + i) * 32);
      if (noise && (i == 5 || i == 15)) start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      if (gapped && i < N * N - 1) begin
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (noise) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_ready", pix_ready, 0);
    chk("result_count", n_res - r0, 4);
    chk("beat_count", n_en - e0, 17);
    chk("done_count", n_done - d0, 1);
`ifdef CONV_SEQ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, gapped ? 15 : 0);
`endif
    for (int j = 0; j < 4; j++) begin
      chk("res_row", rec_row[r0 + j], j / 2);
      chk("res_col", rec_col[r0 + j], j % 2);
      chk("res_data", rec_dat[r0 + j], exp_sum(j, base));
    end
  endtask

  initial begin
    int r0;
    int d0;
    rst       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    #7;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_conv_en", conv_en, 0);
    chk("rst_conv_data", conv_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", pix_ready, 0);

    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b1);

    // Abort a frame right after pixel 9 with the next pixel already offered.
    r0 = n_res;
    d0 = n_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(i * 32);
      @(posedge clk); #1;
    end
    pix_data = DW'(10 * 32);
    chk("pre_abort_conv_en", conv_en, 1);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", pix_ready, 0);
    chk("abort_conv_en", conv_en, 0);
    chk("abort_conv_data", conv_data, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0);
    pix_valid = 1'b0;
    pix_data  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_results", n_res - r0, 0);
    chk("abort_no_done", n_done - d0, 0);

    run_frame(0, 1'b0, 1'b0);
    run_frame(16, 1'b0, 1'b0);
    chk("total_frames", n_done, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
